// File: rtl/fwrisc_wb_arb_pkg.sv
// Shared types and constants for the round-robin Wishbone arbiter.
// Holds the FSM state enum, index width and watchdog counter width.
package fwrisc_wb_arb_pkg;

  localparam int MAX_INIT = 4;
  localparam int IDX_W    = 2;
  localparam int TO_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    TURN  = 2'd2,
    ABORT = 2'd3
  } wb_arb_state_e;

endpackage

// File: rtl/fwrisc_wb_rr_pick.sv
// Combinational round-robin picker: one-hot pick of the first requester
// after index last (circular). Ports: req, last in; pick, valid out.
module fwrisc_wb_rr_pick
  import fwrisc_wb_arb_pkg::*;
#(
  parameter int N_INIT = 2
) (
  input  logic [N_INIT-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [N_INIT-1:0] pick,
  output logic              valid
);

  // Walk offsets from farthest to nearest so the nearest
  // requester after last is the final assignment.
  always_comb begin
    pick = '0;
    for (int off = N_INIT; off >= 1; off--) begin
      for (int i = 0; i < N_INIT; i++) begin
        if (((int'(last) + off) % N_INIT) == i && req[i]) begin
          pick    = '0;
          pick[i] = 1'b1;
        end
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/fwrisc_wb_arbiter.sv
// Round-robin Wishbone arbiter: N_INIT initiators (i_*) share one target
// (t_*); grant held for the whole cyc; gnt one-hot. Optional watchdog
// under FWRISC_WB_ARB_TIMEOUT_EN terminates stalled transfers with err.
module fwrisc_wb_arbiter
  import fwrisc_wb_arb_pkg::*;
#(
  parameter int N_INIT  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_INIT*ADDR_W-1:0] i_adr,
  input  logic [N_INIT*DATA_W-1:0] i_dat_w,
  input  logic [N_INIT*4-1:0]      i_sel,
  input  logic [N_INIT*4-1:0]      i_tgc,
  input  logic [N_INIT-1:0]        i_cyc,
  input  logic [N_INIT-1:0]        i_stb,
  input  logic [N_INIT-1:0]        i_we,
  output logic [DATA_W-1:0]        i_dat_r,
  output logic [N_INIT-1:0]        i_ack,
  output logic [N_INIT-1:0]        i_err,
  output logic [ADDR_W-1:0]        t_adr,
  output logic [DATA_W-1:0]        t_dat_w,
  output logic [3:0]               t_sel,
  output logic [3:0]               t_tgc,
  output logic                     t_cyc,
  output logic                     t_stb,
  output logic                     t_we,
  input  logic [DATA_W-1:0]        t_dat_r,
  input  logic                     t_ack,
  input  logic                     t_err,
  output logic [N_INIT-1:0]        gnt
);

  if (N_INIT < 2 || N_INIT > MAX_INIT ||
      TIMEOUT < 1 || TIMEOUT >= (1 << TO_W)) begin : g_bad_cfg
    $error("fwrisc_wb_arbiter: bad parameters");
  end

  wb_arb_state_e     state;
  logic [N_INIT-1:0] gnt_q;
  logic [N_INIT-1:0] req;
  logic [N_INIT-1:0] pick;
  logic              pick_vld;
  logic [IDX_W-1:0]  g;
  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  pick_idx;
  logic              busy;
  logic              cyc_g;
  logic              to_hit;
  logic              fwd;

  assign req = i_cyc & i_stb;

  fwrisc_wb_rr_pick #(
    .N_INIT(N_INIT)
  ) u_pick (
    .req  (req),
    .last (last),
    .pick (pick),
    .valid(pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_INIT; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  assign busy  = (state == BUSY);
  assign cyc_g = |(i_cyc & gnt_q);

`ifdef FWRISC_WB_ARB_TIMEOUT_EN
  logic [TO_W-1:0] cnt;
  logic            stb_g;

  assign stb_g  = |(i_stb & gnt_q);
  assign to_hit = busy && (cnt == TO_W'(TIMEOUT));

  // Leaving BUSY clears the count, so every grant starts at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!busy || t_ack || t_err) begin
      cnt <= '0;
    end else if (stb_g && !to_hit) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // A watchdog hit drops the target request in the same cycle.
  assign fwd = busy & ~to_hit;

  always_comb begin
    t_adr   = '0;
    t_dat_w = '0;
    t_sel   = '0;
    t_tgc   = '0;
    t_cyc   = 1'b0;
    t_stb   = 1'b0;
    t_we    = 1'b0;
    for (int i = 0; i < N_INIT; i++) begin
      if (fwd && gnt_q[i]) begin
        t_adr   = i_adr[i*ADDR_W +: ADDR_W];
        t_dat_w = i_dat_w[i*DATA_W +: DATA_W];
        t_sel   = i_sel[i*4 +: 4];
        t_tgc   = i_tgc[i*4 +: 4];
        t_cyc   = i_cyc[i];
        t_stb   = i_stb[i];
        t_we    = i_we[i];
      end
    end
  end

  assign i_dat_r = t_dat_r;
  assign i_ack   = fwd  ? (gnt_q & {N_INIT{t_ack & ~t_err}}) : '0;
  assign i_err   = busy ? (gnt_q & {N_INIT{t_err | to_hit}}) : '0;
  assign gnt     = gnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt_q <= '0;
      g     <= '0;
      last  <= IDX_W'(N_INIT - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            state <= BUSY;
            gnt_q <= pick;
            g     <= pick_idx;
          end
        end
        BUSY: begin
          if (!cyc_g) begin
            state <= TURN;
            gnt_q <= '0;
            last  <= g;
          end
`ifdef FWRISC_WB_ARB_TIMEOUT_EN
          else if (to_hit) begin
            state <= ABORT;
          end
`endif
        end
`ifdef FWRISC_WB_ARB_TIMEOUT_EN
        ABORT: begin
          if (!cyc_g) begin
            state <= TURN;
            gnt_q <= '0;
            last  <= g;
          end
        end
`endif
        TURN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fwrisc_wb_arbiter.sv
// Testbench for fwrisc_wb_arbiter: directed transfers, scoreboard queue
// checked by a negedge monitor on every target response.
module tb_fwrisc_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] i_adr;
  logic [63:0] i_dat_w;
  logic [7:0]  i_sel;
  logic [7:0]  i_tgc;
  logic [1:0]  i_cyc;
  logic [1:0]  i_stb;
  logic [1:0]  i_we;
  logic [31:0] i_dat_r;
  logic [1:0]  i_ack;
  logic [1:0]  i_err;
  logic [31:0] t_adr;
  logic [31:0] t_dat_w;
  logic [3:0]  t_sel;
  logic [3:0]  t_tgc;
  logic        t_cyc;
  logic        t_stb;
  logic        t_we;
  logic [31:0] t_dat_r;
  logic        t_ack;
  logic        t_err;
  logic [1:0]  gnt;

  int n_cmp = 0;
  int n_bad = 0;
  int tmode = 0;
  int tlat  = 0;

  typedef struct {
    int          ini;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    logic [3:0]  tgc;
    logic        err;
  } exp_t;

  exp_t q[$];

  fwrisc_wb_arbiter #(
    .N_INIT (2),
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(8)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .i_adr  (i_adr),
    .i_dat_w(i_dat_w),
    .i_sel  (i_sel),
    .i_tgc  (i_tgc),
    .i_cyc  (i_cyc),
    .i_stb  (i_stb),
    .i_we   (i_we),
    .i_dat_r(i_dat_r),
    .i_ack  (i_ack),
    .i_err  (i_err),
    .t_adr  (t_adr),
    .t_dat_w(t_dat_w),
    .t_sel  (t_sel),
    .t_tgc  (t_tgc),
    .t_cyc  (t_cyc),
    .t_stb  (t_stb),
    .t_we   (t_we),
    .t_dat_r(t_dat_r),
    .t_ack  (t_ack),
    .t_err  (t_err),
    .gnt    (gnt)
  );

  always #5 clock = ~clock;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_push(int ini, logic [31:0] adr, logic [31:0] dat,
                          logic we, logic [3:0] sel, logic [3:0] tgc,
                          logic err);
    exp_t e;
    e.ini = ini; e.adr = adr; e.dat = dat; e.we = we;
    e.sel = sel; e.tgc = tgc; e.err = err;
    q.push_back(e);
  endtask

  task automatic drive(int i, logic [31:0] adr, logic [31:0] dat,
                       logic we, logic [3:0] sel, logic [3:0] tgc);
    i_adr[i*32 +: 32]  = adr;
    i_dat_w[i*32 +: 32] = dat;
    i_sel[i*4 +: 4]    = sel;
    i_tgc[i*4 +: 4]    = tgc;
    i_we[i]  = we;
    i_cyc[i] = 1'b1;
    i_stb[i] = 1'b1;
  endtask

  task automatic wait_resp(int i);
    int t = 0;
    @(negedge clock);
    while (!(i_ack[i] || i_err[i]) && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL resp_timeout init%0d", i);
    end
  endtask

  task automatic xfer(int i, logic [31:0] adr, logic [31:0] dat,
                      logic we, logic [3:0] sel, logic [3:0] tgc,
                      bit keep);
    @(posedge clock); #1;
    drive(i, adr, dat, we, sel, tgc);
    wait_resp(i);
    @(posedge clock); #1;
    i_stb[i] = 1'b0;
    if (!keep) i_cyc[i] = 1'b0;
  endtask

  // Target model: ack (or ack+err) after tlat stall cycles, or never.
  initial begin
    int wcnt = 0;
    t_ack = 1'b0;
    t_err = 1'b0;
    t_dat_r = '0;
    forever begin
      @(posedge clock); #2;
      if (t_ack || t_err) begin
        t_ack = 1'b0;
        t_err = 1'b0;
        wcnt  = 0;
      end else if (t_cyc && t_stb && tmode != 2) begin
        if (wcnt >= tlat) begin
          t_ack   = 1'b1;
          t_err   = (tmode == 1);
          t_dat_r = 32'hD000_0000 | {16'h0, t_adr[15:0]};
          wcnt    = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: one-hot grant every cycle, scoreboard on each response.
  always @(negedge clock) begin
    chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
    if (!reset && t_cyc && t_stb && (t_ack || t_err)) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got adr %0h expected none", t_adr);
      end else begin
        exp_t e;
        logic [1:0] oh;
        e  = q.pop_front();
        oh = 2'b01 << e.ini;
        chk("sb_gnt", 64'(gnt), 64'(oh));
        chk("sb_adr", 64'(t_adr), 64'(e.adr));
        chk("sb_dat_w", 64'(t_dat_w), 64'(e.dat));
        chk("sb_we", 64'(t_we), 64'(e.we));
        chk("sb_sel", 64'(t_sel), 64'(e.sel));
        chk("sb_tgc", 64'(t_tgc), 64'(e.tgc));
        chk("sb_ack", 64'(i_ack), e.err ? 64'd0 : 64'(oh));
        chk("sb_err", 64'(i_err), e.err ? 64'(oh) : 64'd0);
        chk("sb_dat_r", 64'(i_dat_r),
            64'(32'hD000_0000 | {16'h0, e.adr[15:0]}));
      end
    end
  end

  initial begin
    reset = 1'b1;
    i_adr = '0; i_dat_w = '0; i_sel = '0; i_tgc = '0;
    i_cyc = '0; i_stb = '0; i_we = '0;
    #12;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_t_cyc", 64'(t_cyc), 64'd0);
    chk("rst_t_stb", 64'(t_stb), 64'd0);
    chk("rst_t_adr", 64'(t_adr), 64'd0);
    chk("rst_i_ack", 64'(i_ack), 64'd0);
    chk("rst_i_err", 64'(i_err), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Single request, exact cycle timing.
    tlat = 2;
    exp_push(0, 32'h1000, 32'h1111_2222, 1'b1, 4'hF, 4'h0, 1'b0);
    @(posedge clock); #1;
    drive(0, 32'h1000, 32'h1111_2222, 1'b1, 4'hF, 4'h0);
    @(negedge clock);
    chk("c0_t_cyc", 64'(t_cyc), 64'd0);
    @(negedge clock);
    chk("c1_t_cyc", 64'(t_cyc), 64'd1);
    chk("c1_t_stb", 64'(t_stb), 64'd1);
    chk("c1_t_adr", 64'(t_adr), 64'h1000);
    chk("c1_gnt", 64'(gnt), 64'd1);
    @(negedge clock);
    chk("c2_i_ack", 64'(i_ack), 64'd0);
    @(negedge clock);
    chk("c3_i_ack", 64'(i_ack), 64'd1);
    @(posedge clock); #1;
    i_cyc[0] = 1'b0;
    i_stb[0] = 1'b0;
    @(negedge clock);
    chk("c4_gnt", 64'(gnt), 64'd1);
    @(negedge clock);
    chk("c5_gnt", 64'(gnt), 64'd0);
    chk("c5_t_cyc", 64'(t_cyc), 64'd0);

    // Simultaneous requests after reset: 0, 1, 0, 1.
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    tlat = 0;
    exp_push(0, 32'h2000, 32'hA0, 1'b1, 4'h3, 4'h0, 1'b0);
    exp_push(1, 32'h2100, 32'hB0, 1'b0, 4'hC, 4'h0, 1'b0);
    exp_push(0, 32'h2004, 32'hA1, 1'b0, 4'h1, 4'h0, 1'b0);
    exp_push(1, 32'h2104, 32'hB1, 1'b1, 4'hF, 4'h0, 1'b0);
    fork
      begin
        xfer(0, 32'h2000, 32'hA0, 1'b1, 4'h3, 4'h0, 1'b0);
        xfer(0, 32'h2004, 32'hA1, 1'b0, 4'h1, 4'h0, 1'b0);
      end
      begin
        xfer(1, 32'h2100, 32'hB0, 1'b0, 4'hC, 4'h0, 1'b0);
        xfer(1, 32'h2104, 32'hB1, 1'b1, 4'hF, 4'h0, 1'b0);
      end
    join

    // AMO lock: initiator 1 holds cyc over two stb phases.
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    tlat = 1;
    exp_push(1, 32'h3000, 32'h55, 1'b0, 4'hF, 4'h2, 1'b0);
    exp_push(1, 32'h3000, 32'h66, 1'b1, 4'hF, 4'h2, 1'b0);
    exp_push(0, 32'h4000, 32'h77, 1'b1, 4'hF, 4'h0, 1'b0);
    fork
      begin
        xfer(1, 32'h3000, 32'h55, 1'b0, 4'hF, 4'h2, 1'b1);
        xfer(1, 32'h3000, 32'h66, 1'b1, 4'hF, 4'h2, 1'b0);
      end
      begin
        repeat (2) @(posedge clock);
        xfer(0, 32'h4000, 32'h77, 1'b1, 4'hF, 4'h0, 1'b0);
      end
    join

    // Error wins over ack.
    tmode = 1;
    tlat  = 0;
    exp_push(1, 32'h5000, 32'h88, 1'b1, 4'hF, 4'h0, 1'b1);
    xfer(1, 32'h5000, 32'h88, 1'b1, 4'hF, 4'h0, 1'b0);
    tmode = 0;
    repeat (3) @(posedge clock);

    // Stalled target.
    tmode = 2;
    @(posedge clock); #1;
`ifdef FWRISC_WB_ARB_TIMEOUT_EN
    drive(0, 32'h6000, 32'h99, 1'b0, 4'hF, 4'h0);
    drive(1, 32'h6100, 32'h9A, 1'b0, 4'hF, 4'h0);
    @(negedge clock);
    @(negedge clock);
    chk("wd_c1_gnt", 64'(gnt), 64'd1);
    repeat (7) @(negedge clock);
    chk("wd_c8_err", 64'(i_err), 64'd0);
    chk("wd_c8_cyc", 64'(t_cyc), 64'd1);
    @(negedge clock);
    chk("wd_c9_err", 64'(i_err), 64'd1);
    chk("wd_c9_cyc", 64'(t_cyc), 64'd0);
    chk("wd_c9_stb", 64'(t_stb), 64'd0);
    @(negedge clock);
    chk("wd_c10_err", 64'(i_err), 64'd0);
    chk("wd_c10_cyc", 64'(t_cyc), 64'd0);
    @(posedge clock); #1;
    i_cyc[0] = 1'b0;
    i_stb[0] = 1'b0;
    tmode = 0;
    exp_push(1, 32'h6100, 32'h9A, 1'b0, 4'hF, 4'h0, 1'b0);
    wait_resp(1);
    @(posedge clock); #1;
    i_cyc[1] = 1'b0;
    i_stb[1] = 1'b0;
`else
    drive(0, 32'h6000, 32'h99, 1'b0, 4'hF, 4'h0);
    repeat (20) @(negedge clock);
    chk("hang_cyc", 64'(t_cyc), 64'd1);
    chk("hang_gnt", 64'(gnt), 64'd1);
    chk("hang_err", 64'(i_err), 64'd0);
    @(posedge clock); #1;
    i_cyc[0] = 1'b0;
    i_stb[0] = 1'b0;
    repeat (2) @(negedge clock);
    chk("abandon_gnt", 64'(gnt), 64'd0);
    tmode = 0;
`endif
    repeat (3) @(posedge clock);

    // Reset during BUSY.
    tmode = 2;
    @(posedge clock); #1;
    drive(0, 32'h7000, 32'h0, 1'b0, 4'hF, 4'h0);
    repeat (3) @(negedge clock);
    chk("rb_gnt_busy", 64'(gnt), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("rb_t_cyc", 64'(t_cyc), 64'd0);
    chk("rb_t_stb", 64'(t_stb), 64'd0);
    chk("rb_gnt", 64'(gnt), 64'd0);
    i_cyc[0] = 1'b0;
    i_stb[0] = 1'b0;
    tmode = 0;
    tlat  = 0;
    @(negedge clock); reset = 1'b0;
    exp_push(0, 32'h8000, 32'hC0, 1'b1, 4'hF, 4'h0, 1'b0);
    exp_push(1, 32'h8100, 32'hC1, 1'b1, 4'hF, 4'h0, 1'b0);
    fork
      xfer(0, 32'h8000, 32'hC0, 1'b1, 4'hF, 4'h0, 1'b0);
      xfer(1, 32'h8100, 32'hC1, 1'b1, 4'hF, 4'h0, 1'b0);
    join
    repeat (3) @(negedge clock);
    chk("sb_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
